mul_sequencer: RTL

- Iterative radix-2 shift-add multiply unit, with its sequencer, for MUL, UMULL and SMULL.
- Sits beside the multicycle controller. The main FSM raises `start` in its execute state and holds in a wait state while `busy` is high.
- Drives the register file's single write port itself, so a long multiply retires as two back-to-back writebacks (RdLo, then RdHi) without extra main-FSM states.

---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_shiftadd.sv | 51 +++++
 rtl/mul_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types for the iterative shift-add multiply unit.
// Op codes, sequencer states and default sizes.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_RADDR = 4;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULL = 2'b01,
        OP_SMULL = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_SIGN,
        S_WB_LO,
        S_WB_HI,
        S_DONE
    } state_e;

endpackage

// File: rtl/mul_shiftadd.sv
// Radix-2 shift-add datapath: accumulator, shifted multiplier, bit counter.
// Clear has priority over step, step over negate.
import mul_pkg::*;

module mul_shiftadd #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_step,
    input  logic                         i_negate,
    input  logic [WIDTH-1:0]             i_mplier,
    input  logic                         i_bit,
    output logic [2*WIDTH-1:0]           o_acc,
    output logic [$clog2(WIDTH)-1:0]     o_cnt,
    output logic                         o_last
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [AW-1:0] r_acc;
    logic [AW-1:0] r_mplier;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_clear) begin
            r_acc    <= '0;
            r_mplier <= {{WIDTH{1'b0}}, i_mplier};
            r_cnt    <= '0;
        end else if (i_step) begin
            // r_mplier already holds mplier << r_cnt
            if (i_bit)
                r_acc <= r_acc + r_mplier;
            r_mplier <= r_mplier << 1;
            r_cnt    <= r_cnt + CW'(1);
        end else if (i_negate) begin
            r_acc <= ~r_acc + AW'(1);
        end
    end

    assign o_acc  = r_acc;
    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_sequencer.sv
// MUL/UMULL/SMULL sequencer: operand capture, sign fix-up and
// back-to-back register-file writeback of the low and high words.
import mul_pkg::*;

module mul_sequencer #(
    parameter int WIDTH = MUL_WIDTH,
    parameter int RADDR = MUL_RADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [RADDR-1:0] rdlo,
    input  logic [RADDR-1:0] rdhi,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             wb_en,
    output logic [RADDR-1:0] wb_addr,
    output logic [WIDTH-1:0] wb_data
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_mcand;
    logic             r_neg;
    logic [RADDR-1:0] r_rdlo;
    logic [RADDR-1:0] r_rdhi;
    logic             r_busy;
    logic             r_done;
    logic             r_wb_en;
    logic [RADDR-1:0] r_wb_addr;
    logic [WIDTH-1:0] r_wb_data;

    op_e              w_op;
    logic             w_smull;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_go;
    logic [AW-1:0]    w_acc;
    logic [CW-1:0]    w_cnt;
    logic             w_last;
    logic [WIDTH-1:0] w_lo;

    assign w_op    = op_e'(op);
    assign w_smull = (w_op == OP_SMULL);
    // Magnitudes are unsigned, so 0x80000000 stays correct
    assign w_a = (w_smull && a[WIDTH-1]) ? ~a + WIDTH'(1) : a;
    assign w_b = (w_smull && b[WIDTH-1]) ? ~b + WIDTH'(1) : b;
    assign w_go = (r_state == S_IDLE) && start && !abort;

    // Low word of -acc equals -(low word of acc)
    assign w_lo = r_neg ? ~w_acc[WIDTH-1:0] + WIDTH'(1)
                        : w_acc[WIDTH-1:0];

    mul_shiftadd #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_go),
        .i_step   (r_state == S_MULT),
        .i_negate ((r_state == S_SIGN) && r_neg),
        .i_mplier (w_b),
        .i_bit    (r_mcand[w_cnt]),
        .o_acc    (w_acc),
        .o_cnt    (w_cnt),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_MUL;
            r_mcand   <= '0;
            r_neg     <= 1'b0;
            r_rdlo    <= '0;
            r_rdhi    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_done    <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: if (start) begin
                        r_op    <= w_op;
                        r_mcand <= w_a;
                        r_neg   <= w_smull & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_rdlo  <= rdlo;
                        r_rdhi  <= rdhi;
                        r_busy  <= 1'b1;
                        if (w_op == OP_RSVD) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_MULT;
                        end
                    end
                    S_MULT: if (w_last) r_state <= S_SIGN;
                    S_SIGN: begin
                        r_state   <= S_WB_LO;
                        r_wb_en   <= 1'b1;
                        r_wb_addr <= r_rdlo;
                        r_wb_data <= w_lo;
                    end
                    S_WB_LO: if (r_op == OP_MUL) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_WB_HI;
                        r_wb_en   <= 1'b1;
                        r_wb_addr <= r_rdhi;
                        r_wb_data <= w_acc[AW-1:WIDTH];
                    end
                    S_WB_HI: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign wb_en   = r_wb_en;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

endmodule
